// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine sequencer: state codes, the msg
// field layout, the wash program table and the field decrement helper.
package wash_pkg;

    typedef enum logic [2:0] {
        ST_SHUTDOWN = 3'd0,
        ST_BEGIN    = 3'd1,
        ST_SET      = 3'd2,
        ST_RUN      = 3'd3,
        ST_ERROR    = 3'd4,
        ST_PAUSE    = 3'd5,
        ST_FINISH   = 3'd6
    } wash_state_e;

    localparam int unsigned MSG_W      = 26;
    localparam int unsigned NUM_FIELDS = 8;

    // Index i is phase Pi; P7 (fill) is executed first.
    localparam int unsigned FIELD_LSB [NUM_FIELDS] = '{0, 3, 6, 10, 13, 16, 19, 23};
    localparam int unsigned FIELD_MSB [NUM_FIELDS] = '{2, 5, 9, 12, 15, 18, 22, 25};

    localparam logic [MSG_W-1:0] PROG_STANDARD = {3'd3, 4'd9, 3'd2, 3'd3, 3'd3, 4'd6, 3'd2, 3'd5};
    localparam logic [MSG_W-1:0] PROG_QUICK    = {3'd1, 4'd4, 3'd1, 3'd1, 3'd2, 4'd3, 3'd1, 3'd2};
    localparam logic [MSG_W-1:0] PROG_RINSE    = {3'd0, 4'd0, 3'd0, 3'd2, 3'd4, 4'd0, 3'd2, 3'd3};
    localparam logic [MSG_W-1:0] PROG_SPIN     = {3'd0, 4'd0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd2, 3'd7};

    function automatic logic [MSG_W-1:0] program_msg(input logic [1:0] sel);
        logic [MSG_W-1:0] res;
        case (sel)
            2'd0:    res = PROG_STANDARD;
            2'd1:    res = PROG_QUICK;
            2'd2:    res = PROG_RINSE;
            2'd3:    res = PROG_SPIN;
            default: res = PROG_STANDARD;
        endcase
        return res;
    endfunction

    function automatic logic field_nonzero(input logic [MSG_W-1:0] msg, input int idx);
        logic [MSG_W-1:0] shifted;
        logic [MSG_W-1:0] mask;
        shifted = msg >> FIELD_LSB[idx];
        mask    = (MSG_W'(1) << (FIELD_MSB[idx] - FIELD_LSB[idx] + 1)) - MSG_W'(1);
        return (shifted & mask) != '0;
    endfunction

    // Subtracting one at the field LSB cannot borrow because the field is nonzero.
    function automatic logic [MSG_W-1:0] decrement_highest(input logic [MSG_W-1:0] msg);
        logic [MSG_W-1:0] res;
        logic             done;
        res  = msg;
        done = 1'b0;
        for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
            if (!done && field_nonzero(msg, i)) begin
                res  = msg - (MSG_W'(1) << FIELD_LSB[i]);
                done = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wash_sequencer_tick_gen.sv
// Time-base prescaler: one-cycle tick every TICK_DIV enabled cycles; the
// count is held at zero while disabled so each enable starts a full period.
module tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic cp,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned     CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick decode and next count.
    always_comb begin
        tick = enable && (cnt_q == CNT_MAX);
        if (!enable) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge cp) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine control core: program selection, phase countdown and the
// registered state/msg bus for the display stage.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned FINISH_HOLD = 5
) (
    input  logic             cp,
    input  logic             reset,
    input  logic             powerBtn,
    input  logic             startPauseBtn,
    input  logic             modeBtn,
    input  logic             fault,
    output logic [2:0]       state,
    output logic [MSG_W-1:0] msg
);

    localparam int unsigned      HOLD_W    = (FINISH_HOLD > 1) ? $clog2(FINISH_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FINISH_HOLD - 1);

    logic [2:0]        state_q, state_d;
    logic [MSG_W-1:0]  msg_q, msg_d;
    logic [1:0]        sel_q, sel_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              tick_s;
    logic              tick_en_s;
    logic [MSG_W-1:0]  msg_dec_s;
    logic              dec_zero_s;

    assign tick_en_s  = (state_q == ST_RUN) || (state_q == ST_FINISH);
    assign msg_dec_s  = decrement_highest(msg_q);
    assign dec_zero_s = (msg_dec_s == '0);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .cp     (cp),
        .reset  (reset),
        .enable (tick_en_s),
        .tick   (tick_s)
    );

    // State and datapath registers.
    always_ff @(posedge cp) begin
        if (reset) begin
            state_q <= ST_SHUTDOWN;
            msg_q   <= '0;
            sel_q   <= 2'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
        end
    end

    // Next state; each branch follows powerBtn > fault > startPauseBtn > modeBtn > tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SHUTDOWN: begin
                if (powerBtn) state_d = ST_BEGIN;
                else          state_d = ST_SHUTDOWN;
            end
            ST_BEGIN: begin
                if (powerBtn) state_d = ST_SHUTDOWN;
                else          state_d = ST_SET;
            end
            ST_SET: begin
                if (powerBtn)           state_d = ST_SHUTDOWN;
                else if (startPauseBtn) state_d = ST_RUN;
                else                    state_d = ST_SET;
            end
            ST_RUN: begin
                if (powerBtn)                  state_d = ST_SHUTDOWN;
                else if (fault)                state_d = ST_ERROR;
                else if (startPauseBtn)        state_d = ST_PAUSE;
                else if (tick_s && dec_zero_s) state_d = ST_FINISH;
                else                           state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (powerBtn)           state_d = ST_SHUTDOWN;
                else if (fault)         state_d = ST_ERROR;
                else if (startPauseBtn) state_d = ST_RUN;
                else                    state_d = ST_PAUSE;
            end
            ST_ERROR: begin
                if (powerBtn)                    state_d = ST_SHUTDOWN;
                else if (startPauseBtn && !fault) state_d = ST_PAUSE;
                else                             state_d = ST_ERROR;
            end
            ST_FINISH: begin
                if (powerBtn)                          state_d = ST_SHUTDOWN;
                else if (startPauseBtn)                state_d = ST_SET;
                else if (tick_s && hold_q == HOLD_LAST) state_d = ST_SHUTDOWN;
                else                                   state_d = ST_FINISH;
            end
            default: state_d = ST_SHUTDOWN;
        endcase
    end

    // Datapath updates keyed on the state being entered or kept.
    always_comb begin
        msg_d  = msg_q;
        sel_d  = sel_q;
        hold_d = '0;
        case (state_d)
            ST_SHUTDOWN: begin
                msg_d = '0;
            end
            ST_BEGIN: begin
                sel_d = 2'd0;
                msg_d = program_msg(2'd0);
            end
            ST_SET: begin
                if (state_q == ST_SET && modeBtn) begin
                    sel_d = sel_q + 2'd1;
                    msg_d = program_msg(sel_q + 2'd1);
                end else if (state_q != ST_SET) begin
                    msg_d = program_msg(sel_q);
                end else begin
                    msg_d = msg_q;
                end
            end
            ST_RUN: begin
                if (state_q == ST_RUN && tick_s) msg_d = msg_dec_s;
                else                             msg_d = msg_q;
            end
            ST_FINISH: begin
                msg_d = '0;
                if (state_q == ST_FINISH && tick_s) hold_d = hold_q + HOLD_W'(1);
                else if (state_q == ST_FINISH)      hold_d = hold_q;
                else                                hold_d = '0;
            end
            ST_PAUSE, ST_ERROR: begin
                msg_d = msg_q;
            end
            default: begin
                msg_d = '0;
            end
        endcase
    end

    assign state = state_q;
    assign msg   = msg_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Randomised + directed bench for wash_sequencer: a per-phase reference model
// predicts state/msg after every edge into a queue that a monitor drains.
module tb_wash_sequencer;

    localparam int TD = 4;
    localparam int FH = 5;

    localparam int S_OFF = 0, S_BEGIN = 1, S_SET = 2, S_RUN = 3;
    localparam int S_ERR = 4, S_PAUSE = 5, S_FIN = 6;

    typedef struct packed {
        logic [2:0]  st;
        logic [25:0] msg;
    } exp_t;

    logic        cp = 1'b0;
    logic        reset = 1'b0;
    logic        powerBtn = 1'b0;
    logic        startPauseBtn = 1'b0;
    logic        modeBtn = 1'b0;
    logic        fault = 1'b0;
    logic [2:0]  state;
    logic [25:0] msg;

    int tests  = 0;
    int failed = 0;
    exp_t exp_q[$];

    // Reference model: phase times as plain integers, P7..P0 -> m_f[7]..m_f[0].
    int m_st = 0, m_sel = 0, m_pre = 0, m_hold = 0;
    int m_f[8];
    int fld_lsb[8] = '{0, 3, 6, 10, 13, 16, 19, 23};
    int prog_tab[4][8] = '{'{3, 9, 2, 3, 3, 6, 2, 5},
                           '{1, 4, 1, 1, 2, 3, 1, 2},
                           '{0, 0, 0, 2, 4, 0, 2, 3},
                           '{0, 0, 0, 0, 0, 0, 2, 7}};

    wash_sequencer #(.TICK_DIV(TD), .FINISH_HOLD(FH)) dut (
        .cp            (cp),
        .reset         (reset),
        .powerBtn      (powerBtn),
        .startPauseBtn (startPauseBtn),
        .modeBtn       (modeBtn),
        .fault         (fault),
        .state         (state),
        .msg           (msg)
    );

    always #5 cp = ~cp;

    function automatic logic [25:0] pack_fields();
        logic [25:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = r | (26'(m_f[i]) << fld_lsb[i]);
        return r;
    endfunction

    task automatic load_prog(input int s);
        for (int j = 0; j < 8; j++) m_f[7 - j] = prog_tab[s][j];
    endtask

    task automatic clear_fields();
        for (int i = 0; i < 8; i++) m_f[i] = 0;
    endtask

    task automatic go_off();
        m_st = S_OFF;
        clear_fields();
    endtask

    task automatic model_step(input bit r, input bit p, input bit s, input bit m, input bit f);
        bit counting, tick;
        int total;
        if (r) begin
            m_st = S_OFF; m_sel = 0; m_pre = 0; m_hold = 0;
            clear_fields();
            return;
        end
        counting = (m_st == S_RUN) || (m_st == S_FIN);
        tick     = counting && (m_pre == TD - 1);
        m_pre    = (counting && !tick) ? m_pre + 1 : 0;
        case (m_st)
            S_OFF:   if (p) begin m_st = S_BEGIN; m_sel = 0; load_prog(0); end
            S_BEGIN: if (p) go_off(); else m_st = S_SET;
            S_SET: begin
                if (p) go_off();
                else if (s) m_st = S_RUN;
                else if (m) begin m_sel = (m_sel + 1) % 4; load_prog(m_sel); end
            end
            S_RUN: begin
                if (p) go_off();
                else if (f) m_st = S_ERR;
                else if (s) m_st = S_PAUSE;
                else if (tick) begin
                    total = 0;
                    for (int i = 7; i >= 0; i--) begin
                        if (m_f[i] > 0) begin m_f[i]--; break; end
                    end
                    for (int i = 0; i < 8; i++) total += m_f[i];
                    if (total == 0) begin m_st = S_FIN; m_hold = 0; end
                end
            end
            S_PAUSE: begin
                if (p) go_off();
                else if (f) m_st = S_ERR;
                else if (s) m_st = S_RUN;
            end
            S_ERR: begin
                if (p) go_off();
                else if (s && !f) m_st = S_PAUSE;
            end
            S_FIN: begin
                if (p) go_off();
                else if (s) begin m_st = S_SET; load_prog(m_sel); end
                else if (tick) begin
                    m_hold++;
                    if (m_hold == FH) go_off();
                end
            end
            default: go_off();
        endcase
    endtask

    // Drive one cycle of inputs and queue the response predicted for the next edge.
    task automatic step(input bit r, input bit p, input bit s, input bit m, input bit f);
        exp_t e;
        @(negedge cp);
        reset = r; powerBtn = p; startPauseBtn = s; modeBtn = m; fault = f;
        model_step(r, p, s, m, f);
        e.st  = 3'(m_st);
        e.msg = pack_fields();
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit f);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, f);
    endtask

    // Monitor: compare DUT outputs just after each edge against the queued prediction.
    always @(posedge cp) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (state !== e.st || msg !== e.msg) begin
                failed++;
                $display("FAIL state_msg t=%0t: got state=%0d msg=%07h, expected state=%0d msg=%07h",
                         $time, state, msg, e.st, e.msg);
            end
        end
    end

    initial begin
        int sp_div, flt_div, pwr_div, guard;
        bit flt;
        clear_fields();

        // Reset, power on, program cycling.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        for (int i = 0; i < 4; i++) begin step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); idle(1, 1'b0); end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Spin program to completion and automatic power-down.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(64, 1'b0);

        // Standard program: pause/resume, fault handling.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(10, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(20, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(9, 1'b0);
        idle(3, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Power-off on the very edge that would tick, with fault raised.
        guard = 0;
        while (!(m_st == S_RUN && m_pre == TD - 1) && guard < 20) begin
            idle(1, 1'b0);
            guard++;
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);

        // finish -> set via startPauseBtn, then reset mid-run.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(40, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(6, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Random blocks with varying event densities.
        flt = 1'b0;
        for (int b = 0; b < 12; b++) begin
            sp_div  = $urandom_range(5, 120);
            flt_div = $urandom_range(20, 400);
            pwr_div = $urandom_range(60, 500);
            for (int c = 0; c < 250; c++) begin
                if ($urandom % flt_div == 0) flt = ~flt;
                step(($urandom % 700) == 0,
                     ($urandom % pwr_div) == 0 || (m_st == S_OFF && ($urandom % 20) == 0),
                     ($urandom % sp_div) == 0,
                     ($urandom % 6) == 0,
                     flt);
            end
        end
        idle(2, 1'b0);

        @(negedge cp);
        @(negedge cp);
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL queue_drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
